// File: rtl/controlador_pilha.sv
// Operand-stack sequencing controller: owns the stack pointer and drives a
// single-port synchronous stack RAM. Optional macro PILHA_PEEK_EN enables op 11 (PEEK).
module controlador_pilha #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic [DATA_W-1:0] cmd_data,
    output logic              rsp_valid,
    output logic              rsp_err,
    output logic [DATA_W-1:0] rsp_a,
    output logic [DATA_W-1:0] rsp_b,
    output logic [ADDR_W:0]   count,
    output logic              full,
    output logic              empty,
    output logic              err_overflow,
    output logic              err_underflow,
    input  logic              err_clr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_wren,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        WRITE = 3'd1,
        RD_A  = 3'd2,
        WT_A  = 3'd3,
        RD_B  = 3'd4,
        WT_B  = 3'd5,
        RESP  = 3'd6
    } state_t;

    localparam logic [1:0]        OP_PUSH  = 2'b00;
    localparam logic [1:0]        OP_POP   = 2'b01;
    localparam logic [1:0]        OP_POP2  = 2'b10;
    localparam logic [1:0]        OP_PEEK  = 2'b11;
    localparam logic [ADDR_W:0]   CNT_ONE  = (ADDR_W+1)'(1);
    localparam logic [ADDR_W:0]   CNT_TWO  = (ADDR_W+1)'(2);
    localparam logic [ADDR_W:0]   CNT_FULL = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0]   CNT_ZERO = (ADDR_W+1)'(0);
    localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] ADDR_TWO = ADDR_W'(2);

    state_t              state_q;
    logic [1:0]          op_q;
    logic [ADDR_W:0]     count_q;
    logic                rsp_valid_q;
    logic                rsp_err_q;
    logic [DATA_W-1:0]   rsp_a_q;
    logic [DATA_W-1:0]   rsp_b_q;
    logic [ADDR_W-1:0]   mem_addr_q;
    logic                mem_wren_q;
    logic [DATA_W-1:0]   mem_wdata_q;
    logic                ovf_q;
    logic                udf_q;

    logic                accept_s;
    logic                full_s;
    logic                empty_s;
    logic                ovf_s;
    logic                udf_s;
    logic                illegal_s;
    logic                reject_s;

    assign full_s  = (count_q == CNT_FULL);
    assign empty_s = (count_q == CNT_ZERO);

    // Classify the command on the bus against the current occupancy.
    always_comb begin
        accept_s  = cmd_valid && (state_q == IDLE);
        ovf_s     = 1'b0;
        udf_s     = 1'b0;
        illegal_s = 1'b0;
        case (cmd_op)
            OP_PUSH: ovf_s = full_s;
            OP_POP:  udf_s = empty_s;
            OP_POP2: udf_s = (count_q < CNT_TWO);
            OP_PEEK: begin
`ifdef PILHA_PEEK_EN
                udf_s = empty_s;
`else
                illegal_s = 1'b1;
`endif
            end
            default: illegal_s = 1'b1;
        endcase
        reject_s = ovf_s || udf_s || illegal_s;
    end

    // Command sequencer, stack pointer, response and RAM port registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            op_q        <= 2'b00;
            count_q     <= CNT_ZERO;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_a_q     <= {DATA_W{1'b0}};
            rsp_b_q     <= {DATA_W{1'b0}};
            mem_addr_q  <= {ADDR_W{1'b0}};
            mem_wren_q  <= 1'b0;
            mem_wdata_q <= {DATA_W{1'b0}};
            ovf_q       <= 1'b0;
            udf_q       <= 1'b0;
        end else begin
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            mem_wren_q  <= 1'b0;

            // A new error in the same cycle as err_clr keeps the flag set.
            if (accept_s && ovf_s) begin
                ovf_q <= 1'b1;
            end else if (err_clr) begin
                ovf_q <= 1'b0;
            end else begin
                ovf_q <= ovf_q;
            end
            if (accept_s && udf_s) begin
                udf_q <= 1'b1;
            end else if (err_clr) begin
                udf_q <= 1'b0;
            end else begin
                udf_q <= udf_q;
            end

            case (state_q)
                IDLE: begin
                    if (accept_s) begin
                        op_q <= cmd_op;
                        if (reject_s) begin
                            state_q     <= RESP;
                            rsp_valid_q <= 1'b1;
                            rsp_err_q   <= 1'b1;
                        end else if (cmd_op == OP_PUSH) begin
                            state_q     <= WRITE;
                            mem_addr_q  <= count_q[ADDR_W-1:0];
                            mem_wdata_q <= cmd_data;
                            mem_wren_q  <= 1'b1;
                        end else begin
                            state_q    <= RD_A;
                            mem_addr_q <= count_q[ADDR_W-1:0] - ADDR_ONE;
                        end
                    end else begin
                        state_q <= IDLE;
                    end
                end
                WRITE: begin
                    state_q     <= RESP;
                    count_q     <= count_q + CNT_ONE;
                    rsp_valid_q <= 1'b1;
                end
                RD_A: state_q <= WT_A;
                WT_A: begin
                    rsp_a_q <= mem_rdata;
                    if (op_q == OP_POP2) begin
                        state_q    <= RD_B;
                        mem_addr_q <= count_q[ADDR_W-1:0] - ADDR_TWO;
                    end else begin
                        state_q     <= RESP;
                        rsp_valid_q <= 1'b1;
                        if (op_q == OP_POP) begin
                            count_q <= count_q - CNT_ONE;
                        end else begin
                            count_q <= count_q;
                        end
                    end
                end
                RD_B: state_q <= WT_B;
                WT_B: begin
                    rsp_b_q     <= mem_rdata;
                    state_q     <= RESP;
                    count_q     <= count_q - CNT_TWO;
                    rsp_valid_q <= 1'b1;
                end
                RESP:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign cmd_ready     = (state_q == IDLE);
    assign rsp_valid     = rsp_valid_q;
    assign rsp_err       = rsp_err_q;
    assign rsp_a         = rsp_a_q;
    assign rsp_b         = rsp_b_q;
    assign count         = count_q;
    assign full          = full_s;
    assign empty         = empty_s;
    assign err_overflow  = ovf_q;
    assign err_underflow = udf_q;
    assign mem_addr      = mem_addr_q;
    assign mem_wren      = mem_wren_q;
    assign mem_wdata     = mem_wdata_q;

endmodule

// File: tb/tb_controlador_pilha.sv
// Scoreboard bench for controlador_pilha: a queue-based stack model predicts each
// response and RAM write; a monitor compares them as the DUT presents them.
module tb_controlador_pilha;

    localparam int DATA_W = 16;
    localparam int DEPTH  = 32;
    localparam int ADDR_W = 5;

    logic              clock;
    logic              reset;
    logic              cmd_valid;
    logic              cmd_ready;
    logic [1:0]        cmd_op;
    logic [DATA_W-1:0] cmd_data;
    logic              rsp_valid;
    logic              rsp_err;
    logic [DATA_W-1:0] rsp_a;
    logic [DATA_W-1:0] rsp_b;
    logic [ADDR_W:0]   count;
    logic              full;
    logic              empty;
    logic              err_overflow;
    logic              err_underflow;
    logic              err_clr;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_wren;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    controlador_pilha #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clock(clock), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_data(cmd_data),
        .rsp_valid(rsp_valid), .rsp_err(rsp_err), .rsp_a(rsp_a), .rsp_b(rsp_b),
        .count(count), .full(full), .empty(empty),
        .err_overflow(err_overflow), .err_underflow(err_underflow), .err_clr(err_clr),
        .mem_addr(mem_addr), .mem_wren(mem_wren), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Single-port synchronous RAM: read data appears one cycle after the address.
    logic [DATA_W-1:0] ram [DEPTH];
    always @(posedge clock) begin
        if (mem_wren) ram[mem_addr] <= mem_wdata;
        mem_rdata <= ram[mem_addr];
    end

    int cyc = 0;
    always @(posedge clock) cyc = cyc + 1;

    typedef struct {
        logic        err;
        logic [15:0] a;
        logic [15:0] b;
        int          cnt;
        logic        ovf;
        logic        udf;
        int          due;
    } exp_t;

    typedef struct {
        int          addr;
        logic [15:0] data;
    } wr_t;

    exp_t exp_q[$];
    wr_t  wr_q[$];

    int          stk[$];
    logic [15:0] m_a = 16'h0000;
    logic [15:0] m_b = 16'h0000;
    logic        m_ovf = 1'b0;
    logic        m_udf = 1'b0;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp = n_cmp + 1;
        if (act !== req) begin
            n_bad = n_bad + 1;
            $display("FAIL %s: got %0h required %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor: every response strobe and every RAM write is checked against the scoreboard.
    always @(negedge clock) begin
        if (reset) begin
            if (rsp_valid) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_rsp", 32'd1, 32'd0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("latency", cyc, e.due);
                    chk("rsp_err", {31'd0, rsp_err}, {31'd0, e.err});
                    chk("rsp_a", {16'd0, rsp_a}, {16'd0, e.a});
                    chk("rsp_b", {16'd0, rsp_b}, {16'd0, e.b});
                    chk("count", {26'd0, count}, e.cnt);
                    chk("full", {31'd0, full}, {31'd0, (e.cnt == DEPTH)});
                    chk("empty", {31'd0, empty}, {31'd0, (e.cnt == 0)});
                    chk("err_overflow", {31'd0, err_overflow}, {31'd0, e.ovf});
                    chk("err_underflow", {31'd0, err_underflow}, {31'd0, e.udf});
                end
            end
            if (mem_wren) begin
                if (wr_q.size() == 0) begin
                    chk("unexpected_write", 32'd1, 32'd0);
                end else begin
                    wr_t w;
                    w = wr_q.pop_front();
                    chk("wr_addr", {27'd0, mem_addr}, w.addr);
                    chk("wr_data", {16'd0, mem_wdata}, {16'd0, w.data});
                end
            end
        end
    end

    task automatic wait_ready();
        int n;
        n = 0;
        @(negedge clock);
        while (!cmd_ready && n < 60) begin
            @(negedge clock);
            n = n + 1;
        end
        chk("ready_timeout", {31'd0, cmd_ready}, 32'd1);
    endtask

    // Stack behaviour from the command rules; returns the response latency.
    function automatic int model_cmd(input logic [1:0] op, input logic [15:0] data, output logic err);
        int lat;
        err = 1'b0;
        lat = 1;
        case (op)
            2'b00: begin
                if (stk.size() == DEPTH) begin
                    err = 1'b1; m_ovf = 1'b1;
                end else begin
                    wr_q.push_back('{addr: stk.size(), data: data});
                    stk.push_back(int'(data));
                    lat = 2;
                end
            end
            2'b01: begin
                if (stk.size() == 0) begin
                    err = 1'b1; m_udf = 1'b1;
                end else begin
                    m_a = 16'(stk.pop_back());
                    lat = 3;
                end
            end
            2'b10: begin
                if (stk.size() < 2) begin
                    err = 1'b1; m_udf = 1'b1;
                end else begin
                    m_a = 16'(stk.pop_back());
                    m_b = 16'(stk.pop_back());
                    lat = 5;
                end
            end
            default: begin
`ifdef PILHA_PEEK_EN
                if (stk.size() == 0) begin
                    err = 1'b1; m_udf = 1'b1;
                end else begin
                    m_a = 16'(stk[stk.size()-1]);
                    lat = 3;
                end
`else
                err = 1'b1;
`endif
            end
        endcase
        return lat;
    endfunction

    task automatic issue(input logic [1:0] op, input logic [15:0] data);
        exp_t e;
        int   lat;
        logic err;
        wait_ready();
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_data  = data;
        lat = model_cmd(op, data, err);
        @(posedge clock);
        #1;
        cmd_valid = 1'b0;
        cmd_data  = 16'($urandom);
        e.err = err;
        e.a   = m_a;
        e.b   = m_b;
        e.cnt = stk.size();
        e.ovf = m_ovf;
        e.udf = m_udf;
        e.due = cyc + lat - 1;
        exp_q.push_back(e);
    endtask

    task automatic clear_flags();
        wait_ready();
        err_clr = 1'b1;
        m_ovf = 1'b0;
        m_udf = 1'b0;
        @(negedge clock);
        err_clr = 1'b0;
        chk("clr_ovf", {31'd0, err_overflow}, 32'd0);
        chk("clr_udf", {31'd0, err_underflow}, 32'd0);
    endtask

    task automatic reset_during_write();
        wait_ready();
        cmd_valid = 1'b1;
        cmd_op    = 2'b00;
        cmd_data  = 16'h5A5A;
        @(posedge clock);
        #1;
        cmd_valid = 1'b0;
        chk("wren_in_write", {31'd0, mem_wren}, 32'd1);
        reset = 1'b0;
        #1;
        chk("rst_wren_drop", {31'd0, mem_wren}, 32'd0);
        chk("rst_count", {26'd0, count}, 32'd0);
        chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        stk.delete();
        m_a = 16'h0000; m_b = 16'h0000; m_ovf = 1'b0; m_udf = 1'b0;
        repeat (2) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        chk("idle_after_rst", {31'd0, cmd_ready}, 32'd1);
        chk("count_after_rst", {26'd0, count}, 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, %0d compared", n_cmp);
        $fatal(1, "watchdog");
    end

    initial begin
        reset     = 1'b0;
        cmd_valid = 1'b0;
        cmd_op    = 2'b00;
        cmd_data  = 16'h0000;
        err_clr   = 1'b0;
        #12;
        chk("rst_count0", {26'd0, count}, 32'd0);
        chk("rst_empty", {31'd0, empty}, 32'd1);
        chk("rst_full", {31'd0, full}, 32'd0);
        chk("rst_rsp", {31'd0, rsp_valid}, 32'd0);
        chk("rst_wren", {31'd0, mem_wren}, 32'd0);
        chk("rst_rsp_a", {16'd0, rsp_a}, 32'd0);
        chk("rst_flags", {30'd0, err_overflow, err_underflow}, 32'd0);
        @(negedge clock);
        reset = 1'b1;

        issue(2'b00, 16'h1234);
        issue(2'b00, 16'hABCD);
        issue(2'b10, 16'h0000);
        issue(2'b01, 16'h0000);
        issue(2'b00, 16'h0777);
        issue(2'b10, 16'h0000);
        clear_flags();
        issue(2'b01, 16'h0000);

        for (int i = 0; i < DEPTH; i++) issue(2'b00, 16'(i));
        issue(2'b00, 16'hFFFF);
        wait_ready();
        chk("ram31_kept", {16'd0, ram[DEPTH-1]}, 32'd31);
        clear_flags();
        for (int i = 0; i < DEPTH / 2; i++) issue(2'b10, 16'h0000);

        issue(2'b00, 16'h0042);
        issue(2'b11, 16'h0000);
        reset_during_write();

        for (int i = 0; i < 400; i++) begin
            int r;
            logic [1:0] op;
            r = $urandom_range(99);
            if (((i / 50) % 2) == 0) op = (r < 70) ? 2'b00 : (r < 80) ? 2'b01 : (r < 90) ? 2'b10 : 2'b11;
            else                     op = (r < 20) ? 2'b00 : (r < 50) ? 2'b01 : (r < 85) ? 2'b10 : 2'b11;
            if ($urandom_range(19) == 0) clear_flags();
            issue(op, 16'($urandom));
        end

        repeat (10) @(negedge clock);
        chk("pending_rsp", exp_q.size(), 32'd0);
        chk("pending_wr", wr_q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
